fft_loader: RTL and testbench

- Write-side initiator for the FFT core: accepts a stream of real audio samples and writes one frame of 2^N points into the core's RAM.
- Drives the core's fft_load / add_rd / din write interface, then pulses fft_start.
- Holds off new samples until the core asserts fft_done, then begins the next frame.
- Sits between the sample front end (ADC/I2S receiver) and the fft core.

---
 rtl/fft_loader_if.sv | 29 ++
 rtl/fft_loader.sv | 116 +++++++++++
 tb/tb_fft_loader.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fft_loader_if.sv
// fft_loader_if: bundles the sample-input handshake and the FFT core write
// interface driven by fft_loader.
//   master - loader view (drives the FFT write bus, accepts samples)
//   slave  - environment view (sample front end + FFT core)
interface fft_loader_if #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9,
    parameter int DROP_W    = 8
);
    logic                   sample_valid;
    logic [BIT_WIDTH-1:0]   sample_in;
    logic                   sample_ready;
    logic                   fft_load;
    logic [N-1:0]           add_rd;
    logic [2*BIT_WIDTH-1:0] din;
    logic                   fft_start;
    logic                   fft_done;
    logic [DROP_W-1:0]      drop_count;

    modport master (
        input  sample_valid, sample_in, fft_done,
        output sample_ready, fft_load, add_rd, din, fft_start, drop_count
    );

    modport slave (
        output sample_valid, sample_in, fft_done,
        input  sample_ready, fft_load, add_rd, din, fft_start, drop_count
    );
endinterface

// File: rtl/fft_loader.sv
// fft_loader: collects 2^N real samples, writes them as complex words
// {real, 0} into the FFT core RAM, pulses fft_start, then waits for
// fft_done before accepting the next frame. Samples offered while not
// ready are counted in a saturating drop counter.
// Build option: define FFT_LOADER_BITREV_EN to write samples at
// bit-reversed addresses (input order for an in-place DIT core).
module fft_loader #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9,
    parameter int DROP_W    = 8
) (
    input  logic         clk,
    input  logic         reset,
    fft_loader_if.master bus
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [N-1:0]           count;
    logic                   ready;
    logic                   accept;
    logic                   last_sample;
    logic                   load_q;
    logic [N-1:0]           addr_q;
    logic [2*BIT_WIDTH-1:0] din_q;
    logic                   start_q;
    logic [DROP_W-1:0]      drop_q;

`ifdef FFT_LOADER_BITREV_EN
    function automatic logic [N-1:0] addr_of(input logic [N-1:0] c);
        logic [N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            r[i] = c[N-1-i];
        end
        return r;
    endfunction
`else
    function automatic logic [N-1:0] addr_of(input logic [N-1:0] c);
        return c;
    endfunction
`endif

    assign ready       = (state == LOAD);
    assign accept      = bus.sample_valid & ready;
    assign last_sample = (count == '1);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fft_done is only honoured in BUSY
    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (accept && last_sample) state_next = START;
            START:   state_next = BUSY;
            BUSY:    if (bus.fft_done) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // Sample counter; wraps to 0 naturally after sample 2^N-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (accept) begin
            count <= count + N'(1);
        end
    end

    // Registered RAM write port and start pulse; address/data hold between strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_q  <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            start_q <= 1'b0;
        end else begin
            load_q  <= accept;
            start_q <= (state == START);
            if (accept) begin
                addr_q <= addr_of(count);
                din_q  <= {bus.sample_in, {BIT_WIDTH{1'b0}}};
            end
        end
    end

    // Saturating count of samples offered while not ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
        end else if (bus.sample_valid && !ready && (drop_q != '1)) begin
            drop_q <= drop_q + DROP_W'(1);
        end
    end

    assign bus.sample_ready = ready;
    assign bus.fft_load     = load_q;
    assign bus.add_rd       = addr_q;
    assign bus.din          = din_q;
    assign bus.fft_start    = start_q;
    assign bus.drop_count   = drop_q;

endmodule

// File: tb/tb_fft_loader.sv
// tb_fft_loader: table-driven check of fft_loader with N=3, BIT_WIDTH=16,
// DROP_W=8, plus hand-written drop-saturation and reset-mid-frame sequences.
// Expected addresses follow FFT_LOADER_BITREV_EN when it is defined.
module tb_fft_loader;

    localparam int BW = 16;
    localparam int NP = 3;
    localparam int DW = 8;

    typedef struct {
        logic        valid;
        logic [15:0] sample;
        logic        done;
        logic        ready;
        logic        load;
        logic [2:0]  addr;
        logic [31:0] din;
        logic        start;
        logic [7:0]  drop;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vectors;
    int   miscompares;
    vec_t vecs[$];

    fft_loader_if #(.BIT_WIDTH(BW), .N(NP), .DROP_W(DW)) bus ();

    fft_loader #(.BIT_WIDTH(BW), .N(NP), .DROP_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ea(input int unsigned k);
        logic [2:0] c;
        c = k[2:0];
`ifdef FFT_LOADER_BITREV_EN
        return {c[0], c[1], c[2]};
`else
        return c;
`endif
    endfunction

    function automatic logic [31:0] mkdin(input logic [15:0] s);
        return {s, 16'h0000};
    endfunction

    function automatic void add_vec(input logic v, input logic [15:0] s, input logic d,
                                    input logic r, input logic l, input logic [2:0] a,
                                    input logic [31:0] dn, input logic st, input logic [7:0] dr);
        vec_t x;
        x.valid = v; x.sample = s; x.done = d;
        x.ready = r; x.load = l; x.addr = a; x.din = dn; x.start = st; x.drop = dr;
        vecs.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic r, input logic l, input logic [2:0] a,
                           input logic [31:0] dn, input logic st, input logic [7:0] dr);
        n_vectors++;
        chk({tag, ".sample_ready"}, 32'(bus.sample_ready), 32'(r));
        chk({tag, ".fft_load"},     32'(bus.fft_load),     32'(l));
        chk({tag, ".add_rd"},       32'(bus.add_rd),       32'(a));
        chk({tag, ".din"},          bus.din,               dn);
        chk({tag, ".fft_start"},    32'(bus.fft_start),    32'(st));
        chk({tag, ".drop_count"},   32'(bus.drop_count),   32'(dr));
    endtask

    task automatic step(input logic v, input logic [15:0] s, input logic d);
        bus.sample_valid = v;
        bus.sample_in    = s;
        bus.fft_done     = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] s2[8];
        logic        any_load;
        logic        any_ready;
        int          n_start;

        n_vectors   = 0;
        miscompares = 0;
        s2[0] = 16'h8000; s2[1] = 16'h7FFF; s2[2] = 16'hFFFF; s2[3] = 16'h0001;
        s2[4] = 16'h0000; s2[5] = 16'hC000; s2[6] = 16'h4000; s2[7] = 16'hFFFE;

        // Frame 1: samples 1..8 back to back, then START/BUSY with drops
        for (int k = 0; k < 8; k++)
            add_vec(1'b1, 16'(k + 1), 1'b0, (k < 7), 1'b1, ea(k), mkdin(16'(k + 1)), 1'b0, 8'd0);
        add_vec(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, ea(7), mkdin(16'd8), 1'b1, 8'd0);
        add_vec(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, ea(7), mkdin(16'd8), 1'b0, 8'd1);
        // valid together with fft_done in BUSY: dropped, loader ready next cycle
        add_vec(1'b1, 16'h5678, 1'b1, 1'b1, 1'b0, ea(7), mkdin(16'd8), 1'b0, 8'd2);
        // Frame 2: one sample every 3rd cycle, extreme data; fft_done on idle
        // cycles must be ignored in LOAD and START
        for (int k = 0; k < 8; k++) begin
            add_vec(1'b1, s2[k], 1'b0, (k < 7), 1'b1, ea(k), mkdin(s2[k]), 1'b0, 8'd2);
            add_vec(1'b0, 16'h0000, 1'b1, (k < 7), 1'b0, ea(k), mkdin(s2[k]), (k == 7), 8'd2);
            add_vec(1'b0, 16'h0000, 1'b0, (k < 7), 1'b0, ea(k), mkdin(s2[k]), 1'b0, 8'd2);
        end

        // Reset state
        reset            = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        bus.fft_done     = 1'b0;
        #1;
        chk_all("reset", 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].valid, vecs[i].sample, vecs[i].done);
            chk_all($sformatf("vec%0d", i), vecs[i].ready, vecs[i].load, vecs[i].addr,
                    vecs[i].din, vecs[i].start, vecs[i].drop);
        end

        // 300 samples offered in BUSY: counter saturates at 255, nothing written
        any_load  = 1'b0;
        any_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 16'(i), 1'b0);
            any_load  |= bus.fft_load;
            any_ready |= bus.sample_ready;
            if (i == 251) begin
                n_vectors++;
                chk("drop_pre_sat", 32'(bus.drop_count), 32'd254);
            end
        end
        n_vectors++;
        chk("drop_sat", 32'(bus.drop_count), 32'd255);
        chk("drop_no_load", 32'(any_load), 32'd0);
        chk("drop_no_ready", 32'(any_ready), 32'd0);

        step(1'b0, 16'h0000, 1'b1);
        chk_all("done_pulse", 1'b1, 1'b0, ea(7), mkdin(s2[7]), 1'b0, 8'd255);

        // Frame 3: five samples, then asynchronous reset mid-frame
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 16'(16'h0100 + k), 1'b0);
            chk_all($sformatf("f3_%0d", k), 1'b1, 1'b1, ea(k), mkdin(16'(16'h0100 + k)), 1'b0, 8'd255);
        end
        bus.sample_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_all("mid_reset", 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Frame 4: full frame restarts at count 0
        n_start = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 16'(16'h0A00 + k), 1'b0);
            n_start += int'(bus.fft_start);
            chk_all($sformatf("f4_%0d", k), (k < 7), 1'b1, ea(k), mkdin(16'(16'h0A00 + k)), 1'b0, 8'd0);
        end
        step(1'b0, 16'h0000, 1'b0);
        n_start += int'(bus.fft_start);
        chk_all("f4_start", 1'b0, 1'b0, ea(7), mkdin(16'h0A07), 1'b1, 8'd0);
        step(1'b0, 16'h0000, 1'b0);
        n_start += int'(bus.fft_start);
        chk_all("f4_busy", 1'b0, 1'b0, ea(7), mkdin(16'h0A07), 1'b0, 8'd0);
        n_vectors++;
        chk("f4_start_count", 32'(n_start), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, miscompares);
        $finish;
    end

endmodule
